// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, instruction-length codes, default reset PC.
// Imported by the fetch unit and by the decoder that sits beside it.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        DECIDE   = 3'd1,
        FETCH_B2 = 3'd2,
        FETCH_B3 = 3'd3,
        ISSUE    = 3'd4,
        HALT     = 3'd5
    } fetch_state_t;

    localparam logic [1:0]  LEN_1 = 2'd1;
    localparam logic [1:0]  LEN_2 = 2'd2;
    localparam logic [1:0]  LEN_3 = 2'd3;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] lo;
        logic [7:0] hi;
    } inst_t;

    // A length code of 0 is treated as a single-byte instruction.
    function automatic logic needs_operand(input logic [1:0] len);
        return (len == LEN_2) || (len == LEN_3);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: 1-3 bytes per instruction, valid 2-4 cycles after FETCH_OP at zero wait.
// Stalls on mem_ready low; holds the issued instruction until inst_ack; HALT exits only via reset.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  ir,
    input  logic [1:0]  inst_length,
    input  logic        halt,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [15:0] pc,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        halted
);

    fetch_state_t state;
    inst_t        inst_q;
    logic [15:0]  pc_q;
    logic         mem_rd_q;
    logic         inst_valid_q;
    logic         halted_q;

    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign ir         = inst_q.op;
    assign operand_lo = inst_q.lo;
    assign operand_hi = inst_q.hi;
    assign mem_rd     = mem_rd_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

    // Output flags are registered alongside each state transition so they track the state exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH_OP;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            mem_rd_q     <= 1'b1;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (mem_ready) begin
                        inst_q.op <= mem_rdata;
                        inst_q.lo <= 8'h00;
                        inst_q.hi <= 8'h00;
                        pc_q      <= pc_q + 16'd1;
                        mem_rd_q  <= 1'b0;
                        state     <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (needs_operand(inst_length)) begin
                        mem_rd_q <= 1'b1;
                        state    <= FETCH_B2;
                    end else begin
                        inst_valid_q <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                FETCH_B2: begin
                    if (mem_ready) begin
                        inst_q.lo <= mem_rdata;
                        pc_q      <= pc_q + 16'd1;
                        if (inst_length == LEN_3) begin
                            state <= FETCH_B3;
                        end else begin
                            mem_rd_q     <= 1'b0;
                            inst_valid_q <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                FETCH_B3: begin
                    if (mem_ready) begin
                        inst_q.hi    <= mem_rdata;
                        pc_q         <= pc_q + 16'd1;
                        mem_rd_q     <= 1'b0;
                        inst_valid_q <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (inst_ack) begin
                        // A redirect is honoured even when the consumed instruction halts.
                        if (branch_taken) begin
                            pc_q <= branch_target;
                        end
                        inst_valid_q <= 1'b0;
                        if (halt) begin
                            halted_q <= 1'b1;
                            state    <= HALT;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state    <= FETCH_OP;
                        end
                    end
                end
                HALT: begin
                    mem_rd_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
                default: begin
                    mem_rd_q     <= 1'b1;
                    inst_valid_q <= 1'b0;
                    halted_q     <= 1'b0;
                    state        <= FETCH_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a byte memory and a small opcode decoder surround the fetch unit.
// RESET_PC is FFFF so the first fetch also exercises the PC wrap.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  ir;
    logic [1:0]  inst_length;
    logic        halt;
    logic [7:0]  operand_lo;
    logic [7:0]  operand_hi;
    logic [15:0] pc;
    logic        inst_valid;
    logic        inst_ack;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halted;

    logic [7:0]  mem [0:65535];
    int          ncmp  = 0;
    int          nfail = 0;
    int          acc_cnt = 0;
    int          vld_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ir(ir), .inst_length(inst_length), .halt(halt),
        .operand_lo(operand_lo), .operand_hi(operand_hi), .pc(pc),
        .inst_valid(inst_valid), .inst_ack(inst_ack),
        .branch_taken(branch_taken), .branch_target(branch_target), .halted(halted)
    );

    assign mem_rdata = mem[mem_addr];

    // Opcode 00 deliberately decodes to length 0, which must behave as a 1-byte instruction.
    always_comb begin
        inst_length = 2'd0;
        halt        = 1'b0;
        case (ir)
            8'h78: inst_length = LEN_1;
            8'h3E: inst_length = LEN_2;
            8'hC3: inst_length = LEN_3;
            8'h76: begin inst_length = LEN_1; halt = 1'b1; end
            default: inst_length = 2'd0;
        endcase
    end

    always @(posedge clk) begin
        if (inst_valid && inst_ack) acc_cnt++;
        if (inst_valid) vld_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!inst_valid && n < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        ncmp++; if (pc !== 16'hFFFF) begin nfail++; $display("FAIL rst_pc: got %h want %h", pc, 16'hFFFF); end
        ncmp++; if (mem_addr !== 16'hFFFF) begin nfail++; $display("FAIL rst_addr: got %h want %h", mem_addr, 16'hFFFF); end
        ncmp++; if (ir !== 8'h00) begin nfail++; $display("FAIL rst_ir: got %h want %h", ir, 8'h00); end
        ncmp++; if (operand_lo !== 8'h00) begin nfail++; $display("FAIL rst_lo: got %h want %h", operand_lo, 8'h00); end
        ncmp++; if (operand_hi !== 8'h00) begin nfail++; $display("FAIL rst_hi: got %h want %h", operand_hi, 8'h00); end
        ncmp++; if (inst_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        ncmp++; if (halted !== 1'b0) begin nfail++; $display("FAIL rst_halted: got %b want 0", halted); end
        ncmp++; if (mem_rd !== 1'b1) begin nfail++; $display("FAIL rst_rd: got %b want 1", mem_rd); end
    endtask

    task automatic test_len0_wrap();
        int n;
        rst_n = 1'b1;
        wait_valid(n);
        ncmp++; if (n !== 2) begin nfail++; $display("FAIL len0_latency: got %0d want 2", n); end
        ncmp++; if (ir !== 8'h00) begin nfail++; $display("FAIL len0_ir: got %h want %h", ir, 8'h00); end
        ncmp++; if (pc !== 16'h0000) begin nfail++; $display("FAIL len0_wrap_pc: got %h want %h", pc, 16'h0000); end
        tick();
        ncmp++; if (inst_valid !== 1'b0) begin nfail++; $display("FAIL len0_valid_drop: got %b want 0", inst_valid); end
        ncmp++; if (mem_rd !== 1'b1) begin nfail++; $display("FAIL len0_next_rd: got %b want 1", mem_rd); end
        ncmp++; if (mem_addr !== 16'h0000) begin nfail++; $display("FAIL len0_next_addr: got %h want %h", mem_addr, 16'h0000); end
    endtask

    task automatic test_mov();
        int n;
        wait_valid(n);
        ncmp++; if (n !== 2) begin nfail++; $display("FAIL mov_latency: got %0d want 2", n); end
        ncmp++; if (ir !== 8'h78) begin nfail++; $display("FAIL mov_ir: got %h want %h", ir, 8'h78); end
        ncmp++; if (operand_lo !== 8'h00) begin nfail++; $display("FAIL mov_lo: got %h want %h", operand_lo, 8'h00); end
        ncmp++; if (pc !== 16'h0001) begin nfail++; $display("FAIL mov_pc: got %h want %h", pc, 16'h0001); end
        tick();
    endtask

    task automatic test_jmp();
        int n;
        wait_valid(n);
        ncmp++; if (n !== 4) begin nfail++; $display("FAIL jmp_latency: got %0d want 4", n); end
        ncmp++; if (ir !== 8'hC3) begin nfail++; $display("FAIL jmp_ir: got %h want %h", ir, 8'hC3); end
        ncmp++; if (operand_lo !== 8'h34) begin nfail++; $display("FAIL jmp_lo: got %h want %h", operand_lo, 8'h34); end
        ncmp++; if (operand_hi !== 8'h12) begin nfail++; $display("FAIL jmp_hi: got %h want %h", operand_hi, 8'h12); end
        ncmp++; if (pc !== 16'h0004) begin nfail++; $display("FAIL jmp_pc: got %h want %h", pc, 16'h0004); end
        branch_taken  = 1'b1;
        branch_target = 16'h1234;
        tick();
        branch_taken  = 1'b0;
        ncmp++; if (mem_addr !== 16'h1234) begin nfail++; $display("FAIL jmp_target: got %h want %h", mem_addr, 16'h1234); end
        ncmp++; if (inst_valid !== 1'b0) begin nfail++; $display("FAIL jmp_valid_drop: got %b want 0", inst_valid); end
    endtask

    task automatic test_mvi();
        int n;
        wait_valid(n);
        ncmp++; if (n !== 3) begin nfail++; $display("FAIL mvi_latency: got %0d want 3", n); end
        ncmp++; if (ir !== 8'h3E) begin nfail++; $display("FAIL mvi_ir: got %h want %h", ir, 8'h3E); end
        ncmp++; if (operand_lo !== 8'h5A) begin nfail++; $display("FAIL mvi_lo: got %h want %h", operand_lo, 8'h5A); end
        ncmp++; if (operand_hi !== 8'h00) begin nfail++; $display("FAIL mvi_hi_cleared: got %h want %h", operand_hi, 8'h00); end
        ncmp++; if (pc !== 16'h1236) begin nfail++; $display("FAIL mvi_pc: got %h want %h", pc, 16'h1236); end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        int a0;
        inst_ack  = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ncmp++; if (pc !== 16'h1236) begin nfail++; $display("FAIL wait_pc[%0d]: got %h want %h", i, pc, 16'h1236); end
            ncmp++; if (ir !== 8'h3E) begin nfail++; $display("FAIL wait_ir[%0d]: got %h want %h", i, ir, 8'h3E); end
        end
        mem_ready = 1'b1;
        wait_valid(n);
        ncmp++; if (n !== 2) begin nfail++; $display("FAIL bp_latency: got %0d want 2", n); end
        a0 = acc_cnt;
        for (int i = 0; i < 2; i++) begin
            tick();
            ncmp++; if (inst_valid !== 1'b1) begin nfail++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, inst_valid); end
            ncmp++; if (ir !== 8'h78) begin nfail++; $display("FAIL bp_ir_hold[%0d]: got %h want %h", i, ir, 8'h78); end
            ncmp++; if (pc !== 16'h1237) begin nfail++; $display("FAIL bp_pc_hold[%0d]: got %h want %h", i, pc, 16'h1237); end
        end
        inst_ack = 1'b1;
        tick();
        tick();
        ncmp++; if (acc_cnt - a0 !== 1) begin nfail++; $display("FAIL bp_accepts: got %0d want 1", acc_cnt - a0); end
    endtask

    task automatic test_halt();
        int n;
        mem[16'hFFFF] = 8'h76;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_valid(n);
        ncmp++; if (ir !== 8'h76) begin nfail++; $display("FAIL hlt_ir: got %h want %h", ir, 8'h76); end
        tick();
        ncmp++; if (halted !== 1'b1) begin nfail++; $display("FAIL hlt_halted: got %b want 1", halted); end
        ncmp++; if (pc !== 16'h0000) begin nfail++; $display("FAIL hlt_pc_wrap: got %h want %h", pc, 16'h0000); end
        for (int i = 0; i < 3; i++) begin
            tick();
            ncmp++; if (mem_rd !== 1'b0) begin nfail++; $display("FAIL hlt_rd[%0d]: got %b want 0", i, mem_rd); end
            ncmp++; if (inst_valid !== 1'b0) begin nfail++; $display("FAIL hlt_valid[%0d]: got %b want 0", i, inst_valid); end
            ncmp++; if (halted !== 1'b1) begin nfail++; $display("FAIL hlt_stays[%0d]: got %b want 1", i, halted); end
        end
        rst_n = 1'b0;
        tick();
        ncmp++; if (halted !== 1'b0) begin nfail++; $display("FAIL hlt_reset_clears: got %b want 0", halted); end
        rst_n = 1'b1;
        wait_valid(n);
        branch_taken  = 1'b1;
        branch_target = 16'hABCD;
        tick();
        branch_taken  = 1'b0;
        ncmp++; if (pc !== 16'hABCD) begin nfail++; $display("FAIL hlt_branch_pc: got %h want %h", pc, 16'hABCD); end
        ncmp++; if (halted !== 1'b1) begin nfail++; $display("FAIL hlt_branch_halted: got %b want 1", halted); end
    endtask

    task automatic test_reset_mid_b2();
        int n;
        int v0;
        mem[16'hFFFF] = 8'h3E;
        mem[16'h0000] = 8'h99;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        v0 = vld_cnt;
        tick();
        tick();
        ncmp++; if (pc !== 16'h0000) begin nfail++; $display("FAIL b2_stall_pc: got %h want %h", pc, 16'h0000); end
        ncmp++; if (mem_rd !== 1'b1) begin nfail++; $display("FAIL b2_stall_rd: got %b want 1", mem_rd); end
        rst_n = 1'b0;
        tick();
        ncmp++; if (pc !== 16'hFFFF) begin nfail++; $display("FAIL b2_rst_pc: got %h want %h", pc, 16'hFFFF); end
        ncmp++; if (ir !== 8'h00) begin nfail++; $display("FAIL b2_rst_ir: got %h want %h", ir, 8'h00); end
        ncmp++; if (vld_cnt - v0 !== 0) begin nfail++; $display("FAIL b2_no_valid: got %0d want 0", vld_cnt - v0); end
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        wait_valid(n);
        ncmp++; if (n !== 3) begin nfail++; $display("FAIL b2_refetch_latency: got %0d want 3", n); end
        ncmp++; if (operand_lo !== 8'h99) begin nfail++; $display("FAIL b2_refetch_lo: got %h want %h", operand_lo, 8'h99); end
        ncmp++; if (pc !== 16'h0001) begin nfail++; $display("FAIL b2_refetch_pc: got %h want %h", pc, 16'h0001); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFF] = 8'h00;
        mem[16'h0000] = 8'h78;
        mem[16'h0001] = 8'hC3;
        mem[16'h0002] = 8'h34;
        mem[16'h0003] = 8'h12;
        mem[16'h1234] = 8'h3E;
        mem[16'h1235] = 8'h5A;
        mem[16'h1236] = 8'h78;
        rst_n         = 1'b0;
        mem_ready     = 1'b1;
        inst_ack      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        test_reset();
        test_len0_wrap();
        test_mov();
        test_jmp();
        test_mvi();
        test_backpressure();
        test_halt();
        test_reset_mid_b2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
